// File: rtl/cdb_arbiter_pkg.sv
// Shared widths, the reserved "no label" tag and producer indices for the CDB arbiter.
package cdb_arbiter_pkg;

    localparam int unsigned CDB_N_SRC      = 3;
    localparam int unsigned CDB_ID_WIDTH   = 4;
    localparam int unsigned CDB_VAL_WIDTH  = 32;
    localparam int unsigned CDB_FIFO_DEPTH = 2;

    localparam logic [CDB_ID_WIDTH-1:0] TAG_NONE = '0;

    localparam int unsigned SRC_ALU = 0;
    localparam int unsigned SRC_LSB = 1;
    localparam int unsigned SRC_BR  = 2;

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-producer result FIFO; ready and nonempty come from the registered count only.
module cdb_src_fifo #(
    parameter int unsigned ID_WIDTH  = 4,
    parameter int unsigned VAL_WIDTH = 32,
    parameter int unsigned DEPTH     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clear,
    input  logic                 push,
    input  logic                 pop,
    input  logic [ID_WIDTH-1:0]  push_tag,
    input  logic [VAL_WIDTH-1:0] push_val,
    output logic                 ready,
    output logic                 nonempty,
    output logic [ID_WIDTH-1:0]  head_tag,
    output logic [VAL_WIDTH-1:0] head_val
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(DEPTH);

    logic [ID_WIDTH-1:0]  tag_mem [DEPTH];
    logic [VAL_WIDTH-1:0] val_mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic                 do_push, do_pop;

    assign ready    = (count_q != COUNT_FULL);
    assign nonempty = (count_q != '0);
    assign head_tag = tag_mem[rd_ptr_q];
    assign head_val = val_mem[rd_ptr_q];

    // A same-cycle pop never frees a slot for the push: ready is pre-edge state.
    assign do_push = en & ~clear & push & ready;
    assign do_pop  = en & ~clear & pop & nonempty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (en) begin
            if (clear) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
                case ({do_push, do_pop})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            tag_mem[wr_ptr_q] <= push_tag;
            val_mem[wr_ptr_q] <= push_val;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin common-data-bus scheduler: one buffered result per cycle onto a registered
// broadcast.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned N_SRC      = CDB_N_SRC,
    parameter int unsigned ID_WIDTH   = CDB_ID_WIDTH,
    parameter int unsigned VAL_WIDTH  = CDB_VAL_WIDTH,
    parameter int unsigned FIFO_DEPTH = CDB_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_in,
    input  logic                       rdy_in,
    input  logic                       flush,
    input  logic [N_SRC-1:0]           src_valid,
    input  logic [N_SRC*ID_WIDTH-1:0]  src_tag,
    input  logic [N_SRC*VAL_WIDTH-1:0] src_val,
    output logic [N_SRC-1:0]           src_ready,
    output logic                       cdb_valid,
    output logic [ID_WIDTH-1:0]        cdb_tag,
    output logic [VAL_WIDTH-1:0]       cdb_val,
    output logic [$clog2(N_SRC)-1:0]   cdb_src
);

    localparam int unsigned SRC_W = $clog2(N_SRC);

    logic [N_SRC-1:0]     nonempty, pop, push;
    logic [ID_WIDTH-1:0]  head_tag [N_SRC];
    logic [VAL_WIDTH-1:0] head_val [N_SRC];
    logic [SRC_W-1:0]     rr_ptr_q, rr_ptr_d, winner;
    logic                 found;
    int                   idx;

    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        // Tag 0 means "no label"; such pushes are dropped here.
        assign push[i] = src_valid[i] &&
                         (src_tag[i*ID_WIDTH +: ID_WIDTH] != ID_WIDTH'(TAG_NONE));
        assign pop[i]  = found && (winner == SRC_W'(i));

        cdb_src_fifo #(
            .ID_WIDTH  (ID_WIDTH),
            .VAL_WIDTH (VAL_WIDTH),
            .DEPTH     (FIFO_DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst      (rst_in),
            .en       (rdy_in),
            .clear    (flush),
            .push     (push[i]),
            .pop      (pop[i]),
            .push_tag (src_tag[i*ID_WIDTH +: ID_WIDTH]),
            .push_val (src_val[i*VAL_WIDTH +: VAL_WIDTH]),
            .ready    (src_ready[i]),
            .nonempty (nonempty[i]),
            .head_tag (head_tag[i]),
            .head_val (head_val[i])
        );
    end

    // First nonempty source at or after rr_ptr, wrapping at N_SRC.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < int'(N_SRC); k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= int'(N_SRC)) idx = idx - int'(N_SRC);
            if (!found && nonempty[idx]) begin
                found  = 1'b1;
                winner = SRC_W'(idx);
            end
        end
        rr_ptr_d = (winner == SRC_W'(N_SRC - 1)) ? '0 : winner + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            rr_ptr_q  <= '0;
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_val   <= '0;
            cdb_src   <= '0;
        end else if (rdy_in) begin
            if (flush) begin
                rr_ptr_q  <= '0;
                cdb_valid <= 1'b0;
            end else if (found) begin
                rr_ptr_q  <= rr_ptr_d;
                cdb_valid <= 1'b1;
                cdb_tag   <= head_tag[winner];
                cdb_val   <= head_val[winner];
                cdb_src   <= winner;
            end else begin
                cdb_valid <= 1'b0;
            end
        end
    end

endmodule
